// File: rtl/four_to_two_encoder_debounced_pkg.sv
// rtl/four_to_two_encoder_debounced_pkg.sv - shared state, code type and encode helpers
// for four_to_two_encoder_debounced.
package four_to_two_enc_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef logic [1:0] code_t;

  // Highest set index wins; an all-zero input also maps to 0 and is
  // distinguished by the caller.
  function automatic code_t encode4(input logic [3:0] d);
    if (d[3])      return 2'd3;
    else if (d[2]) return 2'd2;
    else if (d[1]) return 2'd1;
    else           return 2'd0;
  endfunction

  function automatic logic is_multi_hot(input logic [3:0] d);
    return (d & (d - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/four_to_two_encoder_debounced_sync2.sv
// rtl/four_to_two_encoder_debounced_sync2.sv - two-flop synchronizer (sync2) for
// asynchronous level inputs.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/four_to_two_encoder_debounced.sv
// rtl/four_to_two_encoder_debounced.sv - debounced 4-to-2 button encoder with V/ready event output;
// MULTI_HOT_ERR_EN rejects multi-hot samples and adds the err pulse output.
module four_to_two_encoder_debounced
  import four_to_two_enc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] D,
  output logic       A,
  output logic       B,
  output logic       V,
  input  logic       ready,
  output logic       ovf
`ifdef MULTI_HOT_ERR_EN
  ,
  output logic       err
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  logic [3:0]       w_d_s;
  code_t            w_code;
  logic             w_any;
  logic             w_multi;
  logic             w_accept;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  code_t            r_cand;
  code_t            r_code;
  logic             r_v;
  logic             r_ovf;

  sync2 #(.WIDTH(4)) u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (D),
    .o_q   (w_d_s)
  );

  assign w_code   = encode4(w_d_s);
  assign w_any    = (w_d_s != 4'd0);
  assign w_accept = r_v & ready;

`ifdef MULTI_HOT_ERR_EN
  assign w_multi = is_multi_hot(w_d_s);
`else
  assign w_multi = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_cand  <= 2'd0;
      r_code  <= 2'd0;
      r_v     <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) r_v <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any && !w_multi) begin
            r_cand  <= w_code;
            r_cnt   <= LP_CNT_ONE;
            r_state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!w_any || w_multi) begin
            r_state <= IDLE;
          end else if (w_code != r_cand) begin
            r_cand <= w_code;
            r_cnt  <= LP_CNT_ONE;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_state <= PRESSED;
            // An accept on this same edge frees the slot for the new event.
            if (!r_v || w_accept) begin
              r_code <= r_cand;
              r_v    <= 1'b1;
            end else begin
              r_ovf <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_any) begin
            r_cnt   <= LP_CNT_ONE;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (w_any) begin
            r_state <= PRESSED;
          end else if (r_cnt == LP_CNT_MAX) begin
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + LP_CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MULTI_HOT_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_multi && ((r_state == IDLE) || (r_state == DEBOUNCE));
  end

  assign err = r_err;
`endif

  assign A   = r_code[1];
  assign B   = r_code[0];
  assign V   = r_v;
  assign ovf = r_ovf;

endmodule
